irq_arbiter: RTL and testbench

IRQ_ARBITER -- requirements
Module: irq_arbiter

---
 rtl/irq_arbiter_if.sv | 24 ++
 rtl/irq_arbiter.sv | 124 ++++++++++++
 tb/tb_irq_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/irq_arbiter_if.sv
// Bundle of the interrupt request, core handshake and peripheral acknowledge signals.
// The slave modport belongs to the arbiter; the master modport belongs to the core/peripheral side.
interface irq_arbiter_if #(
    parameter int NUM_VECT = 45
);
    logic [NUM_VECT-1:1] irq;
    logic                global_ie;
    logic                core_ack;
    logic                irq_req;
    logic [5:0]          irq_vector;
    logic                irqack;
    logic [5:0]          irqack_addr;
    logic                wake;

    modport slave (
        input  irq, global_ie, core_ack,
        output irq_req, irq_vector, irqack, irqack_addr, wake
    );

    modport master (
        output irq, global_ie, core_ack,
        input  irq_req, irq_vector, irqack, irqack_addr, wake
    );
endinterface

// File: rtl/irq_arbiter.sv
// Fixed-priority interrupt arbiter: offers the lowest pending vector to the core.
// After an acknowledge it blanks arbitration so the peripheral can clear its flag.
//
// state | meaning
// IDLE  | arbitrate pending irq bits when global_ie is set
// REQ   | vector offered to core, waiting for core_ack or withdrawal
// ACK   | one-cycle irqack pulse to peripherals
// BLANK | no arbitration while the blank counter runs down
module irq_arbiter #(
    parameter int NUM_VECT  = 45,
    parameter int BLANK_CYC = 1
) (
    input logic         cp2,
    input logic         ireset,
    irq_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ACK   = 2'd2,
        BLANK = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic        req_q, req_d;
    logic [5:0]  vec_q, vec_d;
    logic        ack_q, ack_d;
    logic [5:0]  addr_q, addr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        wake_q;

    logic [63:0] irq_full;
    logic [5:0]  win;
    logic        any_irq;
    logic        held;

    // Widened copy so the 6-bit vector can index it for any legal NUM_VECT.
    always_comb begin
        irq_full                = '0;
        irq_full[NUM_VECT-1:1]  = bus.irq;
        any_irq                 = |bus.irq;
        held                    = irq_full[vec_q];
        win                     = '0;
        for (int i = 63; i >= 1; i--) begin
            if (irq_full[i]) win = 6'(i);
        end
    end

    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            state  <= IDLE;
            req_q  <= 1'b0;
            vec_q  <= '0;
            ack_q  <= 1'b0;
            addr_q <= '0;
            cnt_q  <= '0;
            wake_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            req_q  <= req_d;
            vec_q  <= vec_d;
            ack_q  <= ack_d;
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            wake_q <= any_irq;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.global_ie && any_irq) state_nxt = REQ;
            REQ: begin
                // Acknowledge wins over a simultaneous withdrawal.
                if (bus.core_ack)                    state_nxt = ACK;
                else if (!held || !bus.global_ie)    state_nxt = IDLE;
            end
            ACK:     state_nxt = BLANK;
            BLANK:   if (cnt_q <= 3'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_d  = req_q;
        vec_d  = vec_q;
        ack_d  = 1'b0;
        addr_d = addr_q;
        cnt_d  = cnt_q;
        case (state)
            IDLE: begin
                req_d = 1'b0;
                if (bus.global_ie && any_irq) begin
                    req_d = 1'b1;
                    vec_d = win;
                end
            end
            REQ: begin
                if (bus.core_ack) begin
                    req_d  = 1'b0;
                    ack_d  = 1'b1;
                    addr_d = vec_q;
                end else if (!held || !bus.global_ie) begin
                    req_d = 1'b0;
                end
            end
            ACK: begin
                req_d = 1'b0;
                cnt_d = 3'(BLANK_CYC);
            end
            BLANK: begin
                req_d = 1'b0;
                cnt_d = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
            end
            default: req_d = 1'b0;
        endcase
    end

    assign bus.irq_req     = req_q;
    assign bus.irq_vector  = vec_q;
    assign bus.irqack      = ack_q;
    assign bus.irqack_addr = addr_q;
    assign bus.wake        = wake_q;
endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: each step queues the expected post-edge outputs,
// which are popped and compared one time unit after the edge.
module tb_irq_arbiter;
    localparam int NV = 45;

    typedef struct packed {
        logic       req;
        logic [5:0] vec;
        logic       ack;
        logic [5:0] addr;
        logic       wake;
    } exp_t;

    logic cp2 = 1'b0;
    logic ireset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    irq_arbiter_if #(.NUM_VECT(NV)) bus ();

    irq_arbiter #(.NUM_VECT(NV), .BLANK_CYC(1)) dut (
        .cp2    (cp2),
        .ireset (ireset),
        .bus    (bus)
    );

    always #5 cp2 = ~cp2;

    function automatic logic [NV-1:1] bits(input int a, input int b);
        logic [NV-1:1] r;
        r = '0;
        if (a != 0) r[a] = 1'b1;
        if (b != 0) r[b] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [NV-1:1] irq_v, input logic ge, input logic ca,
                        input logic e_req, input logic [5:0] e_vec, input logic e_ack,
                        input logic [5:0] e_addr, input logic e_wake, input string tag);
        exp_t e;
        bus.irq       = irq_v;
        bus.global_ie = ge;
        bus.core_ack  = ca;
        e = '{req: e_req, vec: e_vec, ack: e_ack, addr: e_addr, wake: e_wake};
        sb.push_back(e);
        @(posedge cp2);
        #1;
        checks++;
        assert (sb.size() > 0) else begin
            failures++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_req"},  {5'd0, bus.irq_req}, {5'd0, e.req});
            chk({tag, "_vec"},  bus.irq_vector,      e.vec);
            chk({tag, "_ack"},  {5'd0, bus.irqack},  {5'd0, e.ack});
            chk({tag, "_addr"}, bus.irqack_addr,     e.addr);
            chk({tag, "_wake"}, {5'd0, bus.wake},    {5'd0, e.wake});
        end
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_req"},  {5'd0, bus.irq_req}, 6'd0);
        chk({tag, "_vec"},  bus.irq_vector,      6'd0);
        chk({tag, "_ack"},  {5'd0, bus.irqack},  6'd0);
        chk({tag, "_addr"}, bus.irqack_addr,     6'd0);
        chk({tag, "_wake"}, {5'd0, bus.wake},    6'd0);
    endtask

    initial begin
        bus.irq       = '0;
        bus.global_ie = 1'b0;
        bus.core_ack  = 1'b0;
        #12;
        all_zero("rst");
        @(posedge cp2);
        #1;
        ireset = 1'b1;

        // single request on vector 1, acknowledged
        step(bits(1, 0), 1, 0, 1, 6'd1,  0, 6'd0,  1, "v1_req");
        step(bits(1, 0), 1, 1, 0, 6'd1,  1, 6'd1,  1, "v1_ack");
        step(bits(0, 0), 1, 0, 0, 6'd1,  0, 6'd1,  0, "v1_blank");
        step(bits(0, 0), 1, 0, 0, 6'd1,  0, 6'd1,  0, "v1_idle");
        step(bits(0, 0), 1, 0, 0, 6'd1,  0, 6'd1,  0, "v1_quiet");

        // priority 5 over 27, no re-arbitration, then back-to-back 27
        step(bits(5, 27), 1, 0, 1, 6'd5,  0, 6'd1,  1, "p_req5");
        step(bits(5, 27) | bits(2, 0), 1, 0, 1, 6'd5, 0, 6'd1, 1, "p_hold5");
        step(bits(5, 27), 1, 1, 0, 6'd5,  1, 6'd5,  1, "p_ack5");
        step(bits(27, 0), 1, 1, 0, 6'd5,  0, 6'd5,  1, "p_ackign");
        step(bits(27, 0), 1, 0, 0, 6'd5,  0, 6'd5,  1, "p_blank");
        step(bits(27, 0), 1, 0, 1, 6'd27, 0, 6'd5,  1, "p_req27");
        step(bits(27, 0), 1, 1, 0, 6'd27, 1, 6'd27, 1, "p_ack27");
        step(bits(0, 0),  1, 0, 0, 6'd27, 0, 6'd27, 0, "p_blank27");
        step(bits(0, 0),  1, 0, 0, 6'd27, 0, 6'd27, 0, "p_idle");

        // withdrawal when the request line drops
        step(bits(3, 0), 1, 0, 1, 6'd3,  0, 6'd27, 1, "w_req3");
        step(bits(0, 0), 1, 0, 0, 6'd3,  0, 6'd27, 0, "w_drop3");
        step(bits(0, 0), 1, 1, 0, 6'd3,  0, 6'd27, 0, "w_ackidle");

        // masked by global_ie, wake still follows irq
        step(bits(2, 0), 0, 0, 0, 6'd3,  0, 6'd27, 1, "m_mask");
        step(bits(2, 0), 0, 0, 0, 6'd3,  0, 6'd27, 1, "m_mask2");
        step(bits(2, 0), 1, 0, 1, 6'd2,  0, 6'd27, 1, "m_req2");

        // ack and global_ie falling together: ack wins
        step(bits(2, 0), 0, 1, 0, 6'd2,  1, 6'd2,  1, "a_ackwin");
        step(bits(0, 0), 1, 0, 0, 6'd2,  0, 6'd2,  0, "a_blank");
        step(bits(0, 0), 1, 0, 0, 6'd2,  0, 6'd2,  0, "a_idle");

        // withdrawal by global_ie falling
        step(bits(4, 0), 1, 0, 1, 6'd4,  0, 6'd2,  1, "g_req4");
        step(bits(4, 0), 0, 0, 0, 6'd4,  0, 6'd2,  1, "g_wdraw");
        step(bits(0, 0), 1, 0, 0, 6'd4,  0, 6'd2,  0, "g_idle");

        // reset asserted while in ACK
        step(bits(6, 0), 1, 0, 1, 6'd6,  0, 6'd2,  1, "r_req6");
        step(bits(6, 0), 1, 1, 0, 6'd6,  1, 6'd6,  1, "r_ack6");
        bus.irq      = '0;
        bus.core_ack = 1'b0;
        #2;
        ireset = 1'b0;
        #1;
        all_zero("r_async");
        @(posedge cp2);
        #1;
        ireset = 1'b1;
        step(bits(0, 0), 1, 0, 0, 6'd0, 0, 6'd0, 0, "r_post1");
        step(bits(0, 0), 1, 0, 0, 6'd0, 0, 6'd0, 0, "r_post2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
